// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package rf_pkg;
    localparam int Width         = 32;
    localparam int Address_Width = 5;

    // Register $0 is hard-wired; writes to it are dropped everywhere.
    localparam logic [Address_Width-1:0] REG_ZERO = '0;

    // One queued auxiliary write. A dead entry still occupies its slot
    // until it reaches the head and is popped without a write.
    typedef struct packed {
        logic                     live;
        logic [Address_Width-1:0] addr;
        logic [Width-1:0]         data;
    } rf_entry_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-port, auxiliary-writer and hazard-lookup signals of the arbiter.
interface rf_wb_arbiter_if #(parameter int FIFO_DEPTH = 4);
    import rf_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                     pipe_we;
    logic [Address_Width-1:0] pipe_addr;
    logic [Width-1:0]         pipe_wd;
    logic                     aux_valid;
    logic                     aux_ready;
    logic [Address_Width-1:0] aux_addr;
    logic [Width-1:0]         aux_wd;
    logic [Address_Width-1:0] rd_addr1;
    logic [Address_Width-1:0] rd_addr2;
    logic                     pend1;
    logic                     pend2;
    logic                     WE3;
    logic [Address_Width-1:0] A3;
    logic [Width-1:0]         WD3;
    logic                     pipe_stall;
    logic [CW-1:0]            fifo_count;
    logic                     proto_err;

    modport master (
        output pipe_we, pipe_addr, pipe_wd,
        output aux_valid, aux_addr, aux_wd,
        output rd_addr1, rd_addr2,
        input  aux_ready, pend1, pend2,
        input  WE3, A3, WD3,
        input  pipe_stall, fifo_count, proto_err
    );

    modport slave (
        input  pipe_we, pipe_addr, pipe_wd,
        input  aux_valid, aux_addr, aux_wd,
        input  rd_addr1, rd_addr2,
        output aux_ready, pend1, pend2,
        output WE3, A3, WD3,
        output pipe_stall, fifo_count, proto_err
    );
endinterface

// File: rtl/rf_wb_fifo.sv
// Circular queue of auxiliary writes with per-entry live bits, an
// address-match kill port and two pending-write lookup ports.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [Address_Width-1:0] push_addr,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    input  logic                     kill_en,
    input  logic [Address_Width-1:0] kill_addr,
    input  logic [Address_Width-1:0] look_addr1,
    input  logic [Address_Width-1:0] look_addr2,
    output rf_entry_t                head,
    output logic                     empty,
    output logic                     full,
    output logic [CW-1:0]            count,
    output logic                     hit1,
    output logic                     hit2
);

    rf_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Storage update. Unoccupied slots always hold live=0 (popped slots are
    // cleared), so kill and lookup can scan every slot without an occupancy
    // mask. The push is applied last so a same-cycle matching push survives.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (kill_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].addr == kill_addr) begin
                        mem[i].live <= 1'b0;
                    end
                end
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (push) begin
                mem[wr_ptr] <= '{live: 1'b1, addr: push_addr, data: push_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head view and occupancy flags from registered state.
    always_comb begin
        head  = mem[rd_ptr];
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
    end

    // Pending lookups over live entries; $0 never reports pending.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live && (mem[i].addr == look_addr1) && (look_addr1 != REG_ZERO)) begin
                hit1 = 1'b1;
            end
            if (mem[i].live && (mem[i].addr == look_addr2) && (look_addr2 != REG_ZERO)) begin
                hit2 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the WB stage (priority) and
// a queued auxiliary writer; a starvation counter forces drain cycles.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1,
    localparam int SW        = $clog2(STARVE_MAX + 1)
) (
    input logic            CLK,
    input logic            RST,
    rf_wb_arbiter_if.slave bus
);

    rf_entry_t                head;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [CW-1:0]            fifo_cnt;
    logic                     hit1;
    logic                     hit2;
    logic                     push;
    logic                     pop;
    logic                     pipe_req;
    logic                     stall;
    logic                     kill_en;
    logic                     we3;
    logic [Address_Width-1:0] a3;
    logic [Width-1:0]         wd3;
    logic [SW-1:0]            starve_cnt;
    logic                     proto_err_q;

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push       (push),
        .push_addr  (bus.aux_addr),
        .push_data  (bus.aux_wd),
        .pop        (pop),
        .kill_en    (kill_en),
        .kill_addr  (bus.pipe_addr),
        .look_addr1 (bus.rd_addr1),
        .look_addr2 (bus.rd_addr2),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_cnt),
        .hit1       (hit1),
        .hit2       (hit2)
    );

    // Request qualification; addr-0 traffic is ignored on both sides and
    // only a pipe write that actually takes the port may kill queued entries.
    always_comb begin
        pipe_req = bus.pipe_we && (bus.pipe_addr != REG_ZERO);
        stall    = !RST && (starve_cnt == SW'(STARVE_MAX)) && !fifo_empty && head.live;
        push     = !RST && bus.aux_valid && !fifo_full && (bus.aux_addr != REG_ZERO);
        kill_en  = !RST && pipe_req && !stall;
    end

    // Write-port select: forced drain, then pipeline, then idle-slot drain.
    always_comb begin
        we3 = 1'b0;
        a3  = REG_ZERO;
        wd3 = '0;
        pop = 1'b0;
        if (!RST) begin
            if (stall) begin
                we3 = 1'b1;
                a3  = head.addr;
                wd3 = head.data;
                pop = 1'b1;
            end else if (pipe_req) begin
                we3 = 1'b1;
                a3  = bus.pipe_addr;
                wd3 = bus.pipe_wd;
                pop = !fifo_empty && !head.live;
            end else if (!fifo_empty) begin
                we3 = head.live;
                a3  = head.addr;
                wd3 = head.data;
                pop = 1'b1;
            end
        end
    end

    // Starvation counter: counts cycles a live head is held off, saturating.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (head.live && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Sticky flag for a pipeline write presented during a forced drain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            proto_err_q <= 1'b0;
        end else if (stall && bus.pipe_we) begin
            proto_err_q <= 1'b1;
        end
    end

    // Output drive.
    always_comb begin
        bus.aux_ready  = !fifo_full;
        bus.WE3        = we3;
        bus.A3         = a3;
        bus.WD3        = wd3;
        bus.pipe_stall = stall;
        bus.fifo_count = fifo_cnt;
        bus.pend1      = hit1;
        bus.pend2      = hit2;
        bus.proto_err  = proto_err_q;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, idle drain, starvation drain,
// kill, full queue with wrap, zero register and protocol error.
module tb_rf_wb_arbiter;

    logic CLK;
    logic RST;
    int   tests;
    int   fails;

    rf_wb_arbiter_if #(.FIFO_DEPTH(4)) bus ();

    rf_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.pipe_we   = we;
        bus.pipe_addr = a;
        bus.pipe_wd   = d;
    endtask

    task automatic set_aux(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.aux_valid = v;
        bus.aux_addr  = a;
        bus.aux_wd    = d;
    endtask

    int exp_a [4] = '{2, 3, 4, 5};

    initial begin
        tests = 0;
        fails = 0;

        // Reset held two cycles with live stimulus.
        RST = 1'b1;
        set_pipe(1'b1, 5'd7, 32'h55);
        set_aux(1'b1, 5'd6, 32'h66);
        bus.rd_addr1 = 5'd6;
        bus.rd_addr2 = 5'd7;
        repeat (2) @(posedge CLK);
        #1;
        sample();
        check("rst_we3", bus.WE3, 0);
        check("rst_aux_ready", bus.aux_ready, 1);
        check("rst_count", bus.fifo_count, 0);
        check("rst_stall", bus.pipe_stall, 0);
        check("rst_pend1", bus.pend1, 0);

        next_cycle();
        RST = 1'b0;
        set_pipe(1'b0, 5'd0, 32'h0);
        set_aux(1'b0, 5'd0, 32'h0);
        bus.rd_addr1 = 5'd0;
        bus.rd_addr2 = 5'd0;
        sample();
        check("idle_we3", bus.WE3, 0);
        check("idle_a3", bus.A3, 0);
        check("idle_wd3", bus.WD3, 0);
        check("idle_count", bus.fifo_count, 0);
        check("idle_proto", bus.proto_err, 0);

        // Aux write into idle pipeline.
        next_cycle();
        set_aux(1'b1, 5'd8, 32'hDEADBEEF);
        bus.rd_addr1 = 5'd8;
        sample();
        check("aux_ready", bus.aux_ready, 1);
        check("aux_no_bypass", bus.WE3, 0);
        check("aux_pend_before_push", bus.pend1, 0);
        next_cycle();
        set_aux(1'b0, 5'd0, 32'h0);
        sample();
        check("aux_pend", bus.pend1, 1);
        check("aux_count", bus.fifo_count, 1);
        check("aux_we3", bus.WE3, 1);
        check("aux_a3", bus.A3, 8);
        check("aux_wd3", bus.WD3, 32'hDEADBEEF);
        next_cycle();
        sample();
        check("aux_count_after", bus.fifo_count, 0);
        check("aux_pend_after", bus.pend1, 0);
        check("aux_we3_after", bus.WE3, 0);

        // Starvation and forced drain.
        next_cycle();
        set_aux(1'b1, 5'd9, 32'h99);
        set_pipe(1'b1, 5'd3, 32'h33);
        bus.rd_addr1 = 5'd9;
        sample();
        check("starve_push_a3", bus.A3, 3);
        next_cycle();
        set_aux(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("starve_pipe_a3", bus.A3, 3);
            check("starve_no_stall", bus.pipe_stall, 0);
            check("starve_pend", bus.pend1, 1);
            next_cycle();
        end
        set_pipe(1'b0, 5'd0, 32'h0);
        sample();
        check("starve_stall", bus.pipe_stall, 1);
        check("starve_we3", bus.WE3, 1);
        check("starve_a3", bus.A3, 9);
        check("starve_wd3", bus.WD3, 32'h99);
        next_cycle();
        sample();
        check("starve_stall_clear", bus.pipe_stall, 0);
        check("starve_count", bus.fifo_count, 0);
        check("starve_proto", bus.proto_err, 0);

        // Kill by newer pipe write.
        bus.rd_addr1 = 5'd0;
        bus.rd_addr2 = 5'd5;
        next_cycle();
        set_aux(1'b1, 5'd5, 32'h11);
        set_pipe(1'b1, 5'd3, 32'h33);
        next_cycle();
        set_aux(1'b0, 5'd0, 32'h0);
        set_pipe(1'b1, 5'd5, 32'h22);
        sample();
        check("kill_we3", bus.WE3, 1);
        check("kill_a3", bus.A3, 5);
        check("kill_wd3", bus.WD3, 32'h22);
        check("kill_pend_before", bus.pend2, 1);
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'h0);
        sample();
        check("kill_pend_after", bus.pend2, 0);
        check("kill_count", bus.fifo_count, 1);
        check("kill_dead_pop_we3", bus.WE3, 0);
        next_cycle();
        sample();
        check("kill_count_after", bus.fifo_count, 0);
        bus.rd_addr2 = 5'd0;

        // Full queue, held fifth push, ordering and wrap.
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            set_pipe(1'b1, 5'd20, 32'hAA);
            set_aux(1'b1, 5'(i), 32'h100 + 32'(i));
            sample();
            check("full_ready", bus.aux_ready, 1);
            check("full_count", bus.fifo_count, 32'(i - 1));
        end
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'h0);
        set_aux(1'b1, 5'd5, 32'h105);
        sample();
        check("full_ready_low", bus.aux_ready, 0);
        check("full_count4", bus.fifo_count, 4);
        check("full_stall", bus.pipe_stall, 1);
        check("full_drain_a3", bus.A3, 1);
        check("full_drain_wd3", bus.WD3, 32'h101);
        next_cycle();
        set_pipe(1'b1, 5'd20, 32'hAA);
        sample();
        check("full_ready_again", bus.aux_ready, 1);
        check("full_count3", bus.fifo_count, 3);
        check("full_pipe_a3", bus.A3, 20);
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'h0);
        set_aux(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sample();
            check("order_we3", bus.WE3, 1);
            check("order_a3", bus.A3, 32'(exp_a[i]));
            check("order_count", bus.fifo_count, 32'(4 - i));
            next_cycle();
        end
        sample();
        check("order_empty", bus.fifo_count, 0);
        check("order_we3_idle", bus.WE3, 0);

        // Zero register and protocol error.
        next_cycle();
        set_aux(1'b1, 5'd0, 32'hBAD);
        sample();
        check("zero_ready", bus.aux_ready, 1);
        check("zero_no_write", bus.WE3, 0);
        next_cycle();
        set_aux(1'b0, 5'd0, 32'h0);
        set_pipe(1'b1, 5'd0, 32'h77);
        sample();
        check("zero_not_queued", bus.fifo_count, 0);
        check("pipe_zero_no_write", bus.WE3, 0);
        next_cycle();
        set_aux(1'b1, 5'd10, 32'hA0);
        set_pipe(1'b1, 5'd3, 32'h33);
        next_cycle();
        set_aux(1'b0, 5'd0, 32'h0);
        repeat (2) next_cycle();
        next_cycle();
        sample();
        check("perr_stall", bus.pipe_stall, 1);
        check("perr_aux_wins", bus.A3, 10);
        check("perr_we3", bus.WE3, 1);
        check("perr_not_yet", bus.proto_err, 0);
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'h0);
        sample();
        check("perr_set", bus.proto_err, 1);
        check("perr_count", bus.fifo_count, 0);
        next_cycle();
        set_aux(1'b1, 5'd11, 32'hB0);
        set_pipe(1'b1, 5'd3, 32'h33);
        sample();
        check("perr_sticky", bus.proto_err, 1);

        // Reset mid-operation discards the queue and clears the flag.
        next_cycle();
        RST = 1'b1;
        set_aux(1'b0, 5'd0, 32'h0);
        sample();
        check("mid_rst_we3", bus.WE3, 0);
        check("mid_rst_count", bus.fifo_count, 1);
        check("mid_rst_proto", bus.proto_err, 1);
        next_cycle();
        RST = 1'b0;
        set_pipe(1'b0, 5'd0, 32'h0);
        sample();
        check("post_rst_count", bus.fifo_count, 0);
        check("post_rst_proto", bus.proto_err, 0);
        check("post_rst_we3", bus.WE3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
